// File: rtl/uart_tx_arbiter.sv
//============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter among NUM_REQ character sources.
//            Fixed priority by default; round-robin with UART_ARB_ROUND_ROBIN_EN.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_BITS   = 8,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [DATA_BITS-1:0]         tx_data,
   output logic                         tx_start,
   input  logic                         tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         arb_busy,
   output logic                         err_timeout
);

   localparam int                 c_IDW      = $clog2(NUM_REQ);
   localparam int                 c_CNT_W    = $clog2(ACK_TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_ACK_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   logic                   r_tx_start;
   logic [NUM_REQ-1:0]     r_req_ready;
   logic [DATA_BITS-1:0]   r_tx_data;
   logic [c_IDW-1:0]       r_grant_id;
   logic                   r_arb_busy;
   logic                   r_err_timeout;
   logic [c_CNT_W-1:0]     r_wait_cnt;
`ifdef UART_ARB_ROUND_ROBIN_EN
   logic [c_IDW-1:0]       r_ptr;
`endif

   logic                   w_found;
   logic [c_IDW-1:0]       w_win;
   logic [c_IDW-1:0]       w_cand;
   logic [DATA_BITS-1:0]   w_data;

   // Candidates are visited in priority order; the first valid one wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef UART_ARB_ROUND_ROBIN_EN
         w_cand = c_IDW'((32'(r_ptr) + 32'(k) + 32'd1) % 32'(NUM_REQ));
`else
         w_cand = c_IDW'(k);
`endif
         if (!w_found && req_valid[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   always_comb begin
      w_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == c_IDW'(i)) begin
            w_data = req_data[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_tx_start    <= 1'b0;
         r_req_ready   <= '0;
         r_tx_data     <= '0;
         r_grant_id    <= '0;
         r_arb_busy    <= 1'b0;
         r_err_timeout <= 1'b0;
         r_wait_cnt    <= '0;
`ifdef UART_ARB_ROUND_ROBIN_EN
         r_ptr         <= c_IDW'(NUM_REQ - 1);
`endif
      end else begin
         r_tx_start    <= 1'b0;
         r_req_ready   <= '0;
         r_err_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_found && !tx_busy) begin
                  r_state     <= WAIT_ACK;
                  r_tx_data   <= w_data;
                  r_grant_id  <= w_win;
                  r_tx_start  <= 1'b1;
                  r_req_ready <= NUM_REQ'(1) << w_win;
                  r_arb_busy  <= 1'b1;
                  r_wait_cnt  <= '0;
`ifdef UART_ARB_ROUND_ROBIN_EN
                  r_ptr       <= w_win;
`endif
               end
            end
            WAIT_ACK: begin
               if (tx_busy) begin
                  r_state <= WAIT_DONE;
               end else if (r_wait_cnt == c_ACK_LAST) begin
                  // Character is dropped, never retried.
                  r_state       <= IDLE;
                  r_err_timeout <= 1'b1;
                  r_arb_busy    <= 1'b0;
                  r_wait_cnt    <= '0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  r_state    <= IDLE;
                  r_arb_busy <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_arb_busy <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready   = r_req_ready;
   assign tx_data     = r_tx_data;
   assign tx_start    = r_tx_start;
   assign grant_id    = r_grant_id;
   assign arb_busy    = r_arb_busy;
   assign err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed scenarios plus randomized traffic for uart_tx_arbiter,
//            every cycle compared against a transaction-level reference model.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int DATA_BITS   = 8;
   localparam int ACK_TIMEOUT = 4;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*DATA_BITS-1:0] req_data;
   logic [NUM_REQ-1:0]           req_ready;
   logic [DATA_BITS-1:0]         tx_data;
   logic                         tx_start;
   logic                         tx_busy;
   logic [$clog2(NUM_REQ)-1:0]   grant_id;
   logic                         arb_busy;
   logic                         err_timeout;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_BITS  (DATA_BITS),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .grant_id   (grant_id),
      .arb_busy   (arb_busy),
      .err_timeout(err_timeout)
   );

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: a transfer is "open" from grant until the transmitter
   // finishes or the acknowledge window of ACK_TIMEOUT sampled cycles expires.
   bit                   m_open   = 1'b0;
   bit                   m_acked  = 1'b0;
   int                   m_waited = 0;
   int                   m_ptr    = NUM_REQ - 1;
   logic                 exp_start;
   logic [NUM_REQ-1:0]   exp_ready;
   logic [DATA_BITS-1:0] exp_data;
   int                   exp_gid;
   logic                 exp_err;

   int rise_in   = -1;
   int busy_left = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int pick(input logic [NUM_REQ-1:0] v);
`ifdef UART_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx = (m_ptr + k) % NUM_REQ;
         if (v[idx]) return idx;
      end
`else
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`endif
      return 0;
   endfunction

   // Consumes the inputs the DUT just sampled and predicts the outputs now visible.
   task automatic model_edge();
      int w;
      exp_start = 1'b0;
      exp_ready = '0;
      exp_err   = 1'b0;
      if (rst) begin
         m_open   = 1'b0;
         exp_data = '0;
         exp_gid  = 0;
         m_ptr    = NUM_REQ - 1;
      end else if (!m_open) begin
         if (req_valid != '0 && !tx_busy) begin
            w         = pick(req_valid);
            exp_start = 1'b1;
            exp_ready = NUM_REQ'(1) << w;
            exp_gid   = w;
            exp_data  = req_data[w*DATA_BITS +: DATA_BITS];
            m_ptr     = w;
            m_open    = 1'b1;
            m_acked   = 1'b0;
            m_waited  = 0;
         end
      end else if (!m_acked) begin
         if (tx_busy) m_acked = 1'b1;
         else begin
            m_waited++;
            if (m_waited == ACK_TIMEOUT) begin
               exp_err = 1'b1;
               m_open  = 1'b0;
            end
         end
      end else if (!tx_busy) begin
         m_open = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      check("tx_start", tx_start, exp_start);
      check("req_ready", req_ready, exp_ready);
      check("tx_data", tx_data, exp_data);
      check("grant_id", grant_id, exp_gid);
      check("arb_busy", arb_busy, m_open);
      check("err_timeout", err_timeout, exp_err);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_start();
      for (int i = 0; i < 20; i++) begin
         step();
         if (tx_start === 1'b1) return;
      end
      check("start_wait", tx_start, 1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      tx_busy   = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Single request from requester 2
      req_valid = 4'b0100;
      req_data  = 32'h00A5_0000;
      step();
      check("d30_start", tx_start, 1'b1);
      check("d30_ready", req_ready, 4'b0100);
      check("d30_data", tx_data, 8'hA5);
      check("d30_gid", grant_id, 2);
      req_valid = '0;
      req_data  = 32'hFFFF_FFFF;
      step();
      tx_busy = 1'b1;
      check("d30_pulse", tx_start, 1'b0);
      repeat (10) step();
      tx_busy = 1'b0;
      check("d30_held", arb_busy, 1'b1);
      check("d30_stable", tx_data, 8'hA5);
      step();
      check("d30_fall", arb_busy, 1'b0);

      // Contention, all four held valid
      do_reset();
      req_data  = 32'h4332_2110;
      req_valid = 4'hF;
      for (int t = 0; t < 4; t++) begin
         wait_start();
`ifdef UART_ARB_ROUND_ROBIN_EN
         check("d31_gid", grant_id, t);
         check("d31_data", tx_data, 32'(8'h10 + 8'h11 * t));
`else
         check("d31_gid", grant_id, 0);
         check("d31_data", tx_data, 8'h10);
`endif
         step();
         tx_busy = 1'b1;
         repeat (3) step();
         tx_busy = 1'b0;
      end
      req_valid = '0;
      repeat (3) step();

      // Acknowledge timeout
      do_reset();
      req_valid = 4'b1000;
      req_data  = 32'h7E00_0000;
      step();
      check("d32_start", tx_start, 1'b1);
      req_valid = '0;
      repeat (3) begin
         step();
         check("d32_quiet", err_timeout, 1'b0);
      end
      step();
      check("d32_err", err_timeout, 1'b1);
      check("d32_idle", arb_busy, 1'b0);
      repeat (4) begin
         step();
         check("d32_noretry", tx_start, 1'b0);
      end

      // Transmitter busy on someone else's behalf
      tx_busy = 1'b1;
      do_reset();
      req_valid = 4'b0001;
      req_data  = 32'h0000_0033;
      repeat (5) begin
         step();
         check("d33_hold", tx_start, 1'b0);
      end
      tx_busy = 1'b0;
      step();
      check("d33_start", tx_start, 1'b1);
      check("d33_data", tx_data, 8'h33);
      req_valid = '0;
      step();
      tx_busy = 1'b1;
      repeat (2) step();
      tx_busy = 1'b0;
      repeat (2) step();

      // Reset while the transmitter is busy with our character
      do_reset();
      req_valid = 4'b0010;
      req_data  = 32'h0000_5A66;
      step();
      check("d34_first", tx_start, 1'b1);
      req_valid = '0;
      step();
      tx_busy = 1'b1;
      repeat (2) step();
      req_valid = 4'b0001;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("d34_start", tx_start, 1'b0);
      check("d34_ready", req_ready, 4'b0000);
      check("d34_data", tx_data, 8'h00);
      check("d34_gid", grant_id, 0);
      check("d34_busy", arb_busy, 1'b0);
      check("d34_err", err_timeout, 1'b0);
      repeat (4) begin
         step();
         check("d34_wait", tx_start, 1'b0);
      end
      tx_busy = 1'b0;
      step();
      check("d34_regrant", tx_start, 1'b1);
      check("d34_regrant_data", tx_data, 8'h66);
      req_valid = '0;
      repeat (6) step();

      // Randomized traffic with a responsive transmitter and occasional resets
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         rst = ($urandom_range(0, 249) == 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
               req_valid[i] = 1'b0;
               req_data[i*DATA_BITS +: DATA_BITS] = DATA_BITS'($urandom);
            end else if (!req_valid[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req_valid[i] = 1'b1;
                  req_data[i*DATA_BITS +: DATA_BITS] = DATA_BITS'($urandom);
               end
            end else if ($urandom_range(0, 7) == 0) begin
               req_data[i*DATA_BITS +: DATA_BITS] = DATA_BITS'($urandom);
            end
         end
         // Delays of ACK_TIMEOUT or more deliberately miss the acknowledge window.
         if (tx_start) rise_in = $urandom_range(0, ACK_TIMEOUT + 1);
         if (rise_in == 0) begin
            busy_left = $urandom_range(1, 8);
            rise_in   = -1;
         end else if (rise_in > 0) begin
            rise_in--;
         end
         if (busy_left == 0 && rise_in < 0 && $urandom_range(0, 40) == 0)
            busy_left = $urandom_range(1, 5);
         tx_busy = (busy_left > 0);
         if (busy_left > 0) busy_left--;
      end
      rst = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
